polyph_tx_ctrl: RTL and testbench

Sequencer for the TX polyphase shaping filters (I and Q branches share it).
- Generates the symbol-shift strobe, the 0..OS-1 coefficient-phase index and a symbol request to the bit source (PRBS/mapper).
- Manages start-up fill of the NBAUD-deep symbol line and a clean stop on a symbol boundary.
- Flags which output samples are valid.
- Sits between the TX top-level control and the polyphase filter instances.

---
 rtl/tx_pkg.sv | 15 +
 rtl/tx_rate_div.sv | 35 +++
 rtl/polyph_tx_ctrl.sv | 131 +++++++++++++
 tb/tb_polyph_tx_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared definitions for the TX polyphase sequencer: FSM encoding and default geometry.
package tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } tx_state_e;

    localparam int TX_OS_DEF    = 4;
    localparam int TX_NBAUD_DEF = 6;
    localparam int TX_PH_W_DEF  = $clog2(TX_OS_DEF);

endpackage

// File: rtl/tx_rate_div.sv
// Sample-rate divider: counts 0..latched divisor while running and pulses o_tick on the last count.
module tx_rate_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_rate_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_lat;

    // The divisor is only captured at start so mid-run changes cannot glitch the sample grid.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
            r_lat <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
            r_lat <= i_rate_div;
        end else if (!i_run) begin
            r_cnt <= '0;
        end else if (r_cnt == r_lat) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_run && (r_cnt == r_lat);

endmodule

// File: rtl/polyph_tx_ctrl.sv
// Sequencer for the TX polyphase shaping filters: symbol strobe, coefficient phase, fill/stop control.
// Optional transmitted-symbol counter enabled by defining TX_SYM_CNT_EN.
module polyph_tx_ctrl
    import tx_pkg::*;
#(
    parameter int OS        = TX_OS_DEF,
    parameter int NBAUD     = TX_NBAUD_DEF,
    parameter int DIV_W     = 8,
    parameter int NB_SYMCNT = 32
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [DIV_W-1:0]      i_rate_div,
    output logic                  o_ctrl,
    output logic                  o_sym_req,
    output logic [$clog2(OS)-1:0] o_phase,
    output logic                  o_sample_tick,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic [NB_SYMCNT-1:0]  o_sym_cnt
);

    localparam int PH_W  = $clog2(OS);
    localparam int FIL_W = $clog2(NBAUD + 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OS - 1);
    localparam logic [FIL_W-1:0] FIL_LAST = FIL_W'(NBAUD - 1);

    tx_state_e        r_state;
    logic [PH_W-1:0]  r_phase;
    logic [FIL_W-1:0] r_fill;
    logic             r_valid;
    logic             w_tick;
    logic             w_strobe;
    logic             w_load;
    logic             w_run;

    assign w_load = (r_state == ST_IDLE) && i_enable;
    assign w_run  = (r_state != ST_IDLE);

    tx_rate_div #(
        .DIV_W (DIV_W)
    ) u_rate_div (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_run      (w_run),
        .i_rate_div (i_rate_div),
        .o_tick     (w_tick)
    );

    // Shift lands on the edge where the phase wraps, so phase 0 always sees the newest symbol.
    assign w_strobe = w_tick && (r_phase == PH_LAST) &&
                      ((r_state == ST_FILL) || (r_state == ST_RUN));

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_phase <= PH_LAST;
            r_fill  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_phase <= PH_LAST;
                    r_fill  <= '0;
                    r_valid <= 1'b0;
                    if (i_enable) r_state <= ST_FILL;
                end
                ST_FILL: begin
                    if (!i_enable) begin
                        r_state <= ST_IDLE;
                        r_phase <= PH_LAST;
                        r_fill  <= '0;
                    end else begin
                        if (w_tick) r_phase <= r_phase + 1'b1;
                        if (w_strobe) begin
                            if (r_fill == FIL_LAST) begin
                                r_state <= ST_RUN;
                                r_fill  <= '0;
                                r_valid <= 1'b1;
                            end else begin
                                r_fill <= r_fill + 1'b1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (w_tick) r_phase <= r_phase + 1'b1;
                    if (!i_enable) r_state <= ST_STOP;
                end
                ST_STOP: begin
                    // Line is still full, so re-enabling resumes without a refill.
                    if (w_tick) r_phase <= r_phase + 1'b1;
                    if (i_enable) begin
                        r_state <= ST_RUN;
                    end else if (w_tick && (r_phase == PH_LAST)) begin
                        r_state <= ST_IDLE;
                        r_phase <= PH_LAST;
                        r_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ctrl        = w_strobe;
    assign o_sym_req     = w_strobe;
    assign o_phase       = r_phase;
    assign o_sample_tick = w_tick;
    assign o_valid       = r_valid;
    assign o_busy        = w_run;

`ifdef TX_SYM_CNT_EN
    logic [NB_SYMCNT-1:0] r_sym_cnt;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sym_cnt <= '0;
        end else if (w_strobe) begin
            r_sym_cnt <= r_sym_cnt + 1'b1;
        end
    end

    assign o_sym_cnt = r_sym_cnt;
`else
    assign o_sym_cnt = '0;
`endif

endmodule

// File: tb/tb_polyph_tx_ctrl.sv
// Self-checking bench for polyph_tx_ctrl: directed scenarios plus random enable traffic vs a behavioural model.
module tb_polyph_tx_ctrl;

    localparam int OS        = 4;
    localparam int NBAUD     = 6;
    localparam int DIV_W     = 8;
    localparam int NB_SYMCNT = 32;

    logic                  clk = 1'b0;
    logic                  i_reset;
    logic                  i_enable;
    logic [DIV_W-1:0]      i_rate_div;
    logic                  o_ctrl;
    logic                  o_sym_req;
    logic [$clog2(OS)-1:0] o_phase;
    logic                  o_sample_tick;
    logic                  o_valid;
    logic                  o_busy;
    logic [NB_SYMCNT-1:0]  o_sym_cnt;

    polyph_tx_ctrl #(
        .OS        (OS),
        .NBAUD     (NBAUD),
        .DIV_W     (DIV_W),
        .NB_SYMCNT (NB_SYMCNT)
    ) dut (
        .clk           (clk),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_rate_div    (i_rate_div),
        .o_ctrl        (o_ctrl),
        .o_sym_req     (o_sym_req),
        .o_phase       (o_phase),
        .o_sample_tick (o_sample_tick),
        .o_valid       (o_valid),
        .o_busy        (o_busy),
        .o_sym_cnt     (o_sym_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Model: transmitter on/off, clocks into current sample, sample phase, symbols shifted since
    // start (line is full once NBAUD have gone in), draining flag while finishing a symbol.
    bit          m_on, m_drain;
    int          m_lat, m_sub, m_ph, m_nsym;
    longint      m_sym;

    function automatic bit m_tick();
        return m_on && (m_sub == m_lat);
    endfunction

    function automatic bit m_shift();
        return m_tick() && (m_ph == OS - 1) && !m_drain;
    endfunction

    function automatic logic [63:0] m_symcnt();
`ifdef TX_SYM_CNT_EN
        return 64'(m_sym & 64'hFFFF_FFFF);
`else
        return 64'd0;
`endif
    endfunction

    task automatic m_idle();
        m_on = 0; m_drain = 0; m_sub = 0; m_ph = OS - 1; m_nsym = 0;
    endtask

    task automatic m_reset();
        m_idle();
        m_lat = 0; m_sym = 0;
    endtask

    task automatic m_adv(input bit en, input int div);
        bit tk, sh, last;
        if (!m_on) begin
            if (en) begin
                m_on = 1; m_lat = div; m_sub = 0; m_ph = OS - 1; m_nsym = 0; m_drain = 0;
            end
            return;
        end
        tk = m_tick(); sh = m_shift(); last = (m_ph == OS - 1);
        if (sh) m_sym++;
        if (m_nsym < NBAUD) begin
            if (!en) begin m_idle(); return; end
            if (sh) m_nsym++;
        end else if (m_drain) begin
            if (en) m_drain = 0;
            else if (tk && last) begin m_idle(); return; end
        end else if (!en) begin
            m_drain = 1;
        end
        if (tk) begin m_ph = (m_ph + 1) % OS; m_sub = 0; end
        else m_sub++;
    endtask

    task automatic cycle();
        m_adv(i_enable, int'(i_rate_div));
        @(negedge clk);
        chk("ctrl",    64'(o_ctrl),        64'(m_shift()));
        chk("sym_req", 64'(o_sym_req),     64'(m_shift()));
        chk("phase",   64'(o_phase),       64'(m_ph));
        chk("tick",    64'(o_sample_tick), 64'(m_tick()));
        chk("valid",   64'(o_valid),       64'(m_on && m_nsym >= NBAUD));
        chk("busy",    64'(o_busy),        64'(m_on));
        chk("sym_cnt", 64'(o_sym_cnt),     m_symcnt());
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctrl"},  64'(o_ctrl),        64'd0);
        chk({tag, "_req"},   64'(o_sym_req),     64'd0);
        chk({tag, "_phase"}, 64'(o_phase),       64'(OS - 1));
        chk({tag, "_tick"},  64'(o_sample_tick), 64'd0);
        chk({tag, "_valid"}, 64'(o_valid),       64'd0);
        chk({tag, "_busy"},  64'(o_busy),        64'd0);
        chk({tag, "_cnt"},   64'(o_sym_cnt),     64'd0);
    endtask

    task automatic run_to_idle(input string tag);
        for (int k = 0; k < 500 && m_on; k++) cycle();
        chk(tag, 64'(m_on), 64'd0);
    endtask

    initial begin
        int first_ctrl, vrise, ph1, ph2, strb, vlow;
        bit ok;

        m_reset();
        i_reset = 1'b0; i_enable = 1'b0; i_rate_div = '0;
        #12;
        chk_reset_vals("rst");
        @(negedge clk);
        i_reset = 1'b1;
        repeat (3) cycle();

        // 1: div=0 fill timing
        i_enable = 1'b1; i_rate_div = 8'd0;
        first_ctrl = 0; vrise = 0; ph1 = -1; ph2 = -1;
        for (int k = 1; k <= 25; k++) begin
            cycle();
            if (o_ctrl && first_ctrl == 0) first_ctrl = k;
            if (o_valid && vrise == 0) vrise = k;
            if (k == 1) ph1 = int'(o_phase);
            if (k == 2) ph2 = int'(o_phase);
        end
        chk("s1_first_ctrl", 64'(first_ctrl), 64'd1);
        chk("s1_ph_c1", 64'(ph1), 64'd3);
        chk("s1_ph_c2", 64'(ph2), 64'd0);
        chk("s1_valid_rise", 64'(vrise), 64'd22);
        i_enable = 1'b0;
        run_to_idle("s1_idle");

        // 2: div=2 fill timing
        i_enable = 1'b1; i_rate_div = 8'd2;
        vrise = 0;
        for (int k = 1; k <= 80; k++) begin
            cycle();
            if (o_valid && vrise == 0) vrise = k;
            i_rate_div = 8'(k);
        end
        chk("s2_valid_rise", 64'(vrise), 64'd64);

        // 3: drop enable at phase 1 in RUN
        for (int k = 0; k < 200 && !(m_nsym >= NBAUD && !m_drain && m_ph == 1); k++) cycle();
        chk("s3_wait", 64'(m_nsym >= NBAUD && m_ph == 1), 64'd1);
        i_enable = 1'b0; strb = 0;
        for (int k = 0; k < 200 && m_on; k++) begin
            cycle();
            strb += int'(o_ctrl);
        end
        chk("s3_no_strobe", 64'(strb), 64'd0);
        chk("s3_phase", 64'(o_phase), 64'd3);
        chk("s3_busy", 64'(o_busy), 64'd0);

        // 4: abort fill after 3 strobes, restart needs full refill
        i_enable = 1'b1; i_rate_div = 8'd1;
        for (int k = 0; k < 200 && m_nsym < 3; k++) cycle();
        chk("s4_wait", 64'(m_nsym), 64'd3);
        i_enable = 1'b0;
        repeat (3) cycle();
        i_enable = 1'b1; strb = 0; ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            cycle();
            if (o_valid) ok = 1;
            else strb += int'(o_ctrl);
        end
        chk("s4_valid", 64'(ok), 64'd1);
        chk("s4_refill", 64'(strb), 64'd6);

        // 5: re-raise enable during STOP at phase 2
        for (int k = 0; k < 100 && m_ph != 0; k++) cycle();
        i_enable = 1'b0;
        for (int k = 0; k < 100 && !(m_drain && m_ph == 2); k++) cycle();
        chk("s5_wait", 64'(m_drain && m_ph == 2), 64'd1);
        i_enable = 1'b1; vlow = 0; strb = 0;
        for (int k = 0; k < 4 * OS; k++) begin
            cycle();
            vlow += int'(!o_valid);
            strb += int'(o_ctrl);
        end
        chk("s5_valid_held", 64'(vlow), 64'd0);
        chk("s5_resumed", 64'(strb > 0), 64'd1);

        // 6: asynchronous reset mid-RUN
        repeat (5) cycle();
        #2 i_reset = 1'b0;
        #1 chk_reset_vals("arst");
        m_reset();
        #1 i_reset = 1'b1;
        for (int k = 0; k < 400 && m_sym < 10; k++) cycle();
        cycle();
`ifdef TX_SYM_CNT_EN
        chk("s6_sym10", 64'(o_sym_cnt), 64'd10);
`else
        chk("s6_sym10", 64'(o_sym_cnt), 64'd0);
`endif

        // Random enable/divider traffic
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 24) == 0) i_enable = ~i_enable;
            i_rate_div = 8'($urandom_range(0, 3));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
